pc_control: RTL and testbench
=============================

PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 Parameter PC_W, default 4, SHALL set the program counter width (16 instructions).
REQ-002 Parameter RESET_PC, default 0, SHALL set the pc value loaded on reset.
REQ-003 Parameter STACK_DEPTH, default 4, SHALL set the return-stack entries (used only with CALL_STACK_EN).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 stall  input  1  SHALL mean: hold pc this cycle.
REQ-007 jmp_en  input  1  SHALL mean: jump request this cycle.
REQ-008 jmp_cond  input  2  SHALL select the jump condition: 00 always, 01 flag_z, 10 flag_n, 11 flag_c.
REQ-009 jmp_addr  input  PC_W  SHALL carry the absolute jump/call target.
REQ-010 flag_z, flag_n, flag_c  input  1 each  SHALL be the ALU flags, sampled in the same cycle as jmp_en.
REQ-011 halt_req  input  1  SHALL request entry to HALT; resume  input  1  SHALL request exit from HALT.
REQ-012 call_en, ret_en  input  1 each  SHALL request a subroutine call or return.
REQ-013 pc  output  PC_W  SHALL be the registered program counter.
REQ-014 flush  output  1  SHALL mark the fetched instruction as discarded (registered).
REQ-015 halted  output  1  SHALL be high while in HALT; stack_err  output  1  SHALL be the sticky stack fault.

Function
REQ-016 The FSM SHALL have exactly three states: RUN, FLUSH and HALT.
REQ-017 In RUN, per-cycle priority SHALL be: halt_req > stall > call_en > ret_en > taken jump > increment.
REQ-018 RUN with halt_req SHALL hold pc and go to HALT; halted SHALL rise the next cycle.
REQ-019 RUN with stall (no halt_req) SHALL hold pc, stay in RUN and ignore jump/call/ret inputs.
REQ-020 A jump SHALL be taken when jmp_en=1 and the condition selected by jmp_cond is true.
REQ-021 A taken jump SHALL load pc<=jmp_addr and go to FLUSH.
REQ-022 An untaken jump SHALL increment pc.
REQ-023 Otherwise RUN SHALL apply pc<=pc+1 modulo 2^PC_W (15 wraps to 0).
REQ-024 FLUSH SHALL last exactly one cycle, drive flush=1, hold pc and ignore stall/jump/call/ret, then go to RUN.
REQ-025 A halt_req seen in FLUSH SHALL move to HALT instead of RUN.
REQ-026 HALT SHALL hold pc with halted=1, go to RUN on resume=1 and ignore all other requests.
REQ-027 halt_req and resume both high in HALT SHALL stay in HALT.
REQ-028 flush SHALL be 0 in every state other than FLUSH.

Reset
REQ-029 rst_n=0 at a posedge SHALL force pc=RESET_PC, state=RUN, flush=0, halted=0, stack_err=0 and stack pointer=0, overriding all other inputs in every state.
REQ-030 The first increment SHALL occur on the first posedge with rst_n=1.

Configuration
REQ-031 Macro PC_CALL_STACK_EN SHALL, when defined, compile in a return stack of STACK_DEPTH entries of width PC_W.
REQ-032 With PC_CALL_STACK_EN, call_en SHALL push pc+1 (mod 2^PC_W), load pc<=jmp_addr and go to FLUSH.
REQ-033 With PC_CALL_STACK_EN, call_en on a full stack SHALL suppress the push, still take the jump and set stack_err.
REQ-034 With PC_CALL_STACK_EN, ret_en SHALL pop the top entry into pc and go to FLUSH.
REQ-035 With PC_CALL_STACK_EN, ret_en on an empty stack SHALL increment pc, set stack_err and stay in RUN.
REQ-036 stack_err SHALL stay set until reset.
REQ-037 Without PC_CALL_STACK_EN, call_en and ret_en SHALL be ignored, stack_err SHALL be tied 0 and no stack storage SHALL exist.

Verification
REQ-038 Reset then 17 free cycles -> pc 0,1,...,15,0; flush=0 throughout.
REQ-039 At pc=3: jmp_en=1, jmp_cond=01, flag_z=0 -> pc=4, no flush; repeat with flag_z=1, jmp_addr=9 -> pc=9, flush=1 one cycle with pc=9, then pc=10.
REQ-040 stall=1 for 3 cycles at pc=5 with jmp_en=1 -> pc stays 5; after release, jump is taken if still requested.
REQ-041 halt_req at pc=7 -> halted=1, pc=7 held 5 cycles; resume -> halted=0, pc=8 the following cycle.
REQ-042 PC_CALL_STACK_EN, STACK_DEPTH=4: call to 12 at pc=2 -> pc=12, flush; ret -> pc=3; 5 nested calls -> stack_err=1 on the 5th, jump still taken; ret on empty stack -> stack_err=1.
REQ-043 rst_n=0 during FLUSH and during HALT -> next cycle pc=0, flush=0, halted=0, stack_err=0.

Source files
------------

// File: rtl/pc_control.sv
// Program counter sequencer: RUN / FLUSH / HALT FSM with conditional jumps.
// Define PC_CALL_STACK_EN to add a STACK_DEPTH-entry return stack for call/ret.
module pc_control #(
   parameter int               PC_W        = 4,
   parameter logic [PC_W-1:0]  RESET_PC    = '0,
   parameter int               STACK_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            jmp_en,
   input  logic [1:0]      jmp_cond,
   input  logic [PC_W-1:0] jmp_addr,
   input  logic            flag_z,
   input  logic            flag_n,
   input  logic            flag_c,
   input  logic            halt_req,
   input  logic            resume,
   input  logic            call_en,
   input  logic            ret_en,
   output logic [PC_W-1:0] pc,
   output logic            flush,
   output logic            halted,
   output logic            stack_err
);

   typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

   state_t          state, state_nx;
   logic [PC_W-1:0] pc_nx;
   logic [PC_W-1:0] pc_inc;
   logic            cond_ok;
   logic            taken;

   assign pc_inc = pc + PC_W'(1);

   always_comb begin
      cond_ok = 1'b0;
      unique case (jmp_cond)
         2'b00: cond_ok = 1'b1;
         2'b01: cond_ok = flag_z;
         2'b10: cond_ok = flag_n;
         2'b11: cond_ok = flag_c;
         default: cond_ok = 1'b0;
      endcase
   end

   assign taken = jmp_en & cond_ok;

`ifdef PC_CALL_STACK_EN
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0]  stk [STACK_DEPTH];
   logic [SP_W-1:0]  sp;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic             full, empty;
   logic             push, pop, err_set;
   logic             err_q;

   assign wr_idx    = sp[IDX_W-1:0];
   assign rd_idx    = wr_idx - IDX_W'(1);
   assign full      = (sp == SP_W'(STACK_DEPTH));
   assign empty     = (sp == '0);
   assign stack_err = err_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{call_en, ret_en, (STACK_DEPTH > 0)};
   assign stack_err  = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
`ifdef PC_CALL_STACK_EN
      push     = 1'b0;
      pop      = 1'b0;
      err_set  = 1'b0;
`endif
      unique case (state)
         RUN: begin
            if (halt_req) begin
               state_nx = HALT;
            end else if (stall) begin
               pc_nx = pc;
`ifdef PC_CALL_STACK_EN
            end else if (call_en) begin
               // A call on a full stack still jumps; only the return address is lost.
               pc_nx    = jmp_addr;
               state_nx = FLUSH;
               if (full) err_set = 1'b1;
               else      push    = 1'b1;
            end else if (ret_en) begin
               if (empty) begin
                  pc_nx   = pc_inc;
                  err_set = 1'b1;
               end else begin
                  pc_nx    = stk[rd_idx];
                  pop      = 1'b1;
                  state_nx = FLUSH;
               end
`endif
            end else if (taken) begin
               pc_nx    = jmp_addr;
               state_nx = FLUSH;
            end else begin
               pc_nx = pc_inc;
            end
         end
         FLUSH:   state_nx = halt_req ? HALT : RUN;
         HALT:    if (resume && !halt_req) state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= RUN;
         pc     <= RESET_PC;
         flush  <= 1'b0;
         halted <= 1'b0;
      end else begin
         state  <= state_nx;
         pc     <= pc_nx;
         flush  <= (state_nx == FLUSH);
         halted <= (state_nx == HALT);
      end
   end

`ifdef PC_CALL_STACK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp    <= '0;
         err_q <= 1'b0;
      end else begin
         if (push)    sp    <= sp + SP_W'(1);
         if (pop)     sp    <= sp - SP_W'(1);
         if (err_set) err_q <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only read below the stack pointer.
   always_ff @(posedge clk) begin
      if (push) stk[wr_idx] <= pc_inc;
   end
`endif

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control with a behavioural reference model and per-cycle compare.
module tb_pc_control;

`ifdef PC_CALL_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stall = 1'b0, jmp_en = 1'b0;
   logic [1:0] jmp_cond = 2'b00;
   logic [3:0] jmp_addr = 4'h0;
   logic       flag_z = 1'b0, flag_n = 1'b0, flag_c = 1'b0;
   logic       halt_req = 1'b0, resume = 1'b0, call_en = 1'b0, ret_en = 1'b0;
   logic [3:0] pc;
   logic       flush, halted, stack_err;

   pc_control #(.PC_W(4), .RESET_PC(4'h0), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .jmp_en(jmp_en), .jmp_cond(jmp_cond),
      .jmp_addr(jmp_addr), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
      .halt_req(halt_req), .resume(resume), .call_en(call_en), .ret_en(ret_en),
      .pc(pc), .flush(flush), .halted(halted), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   // Reference model: pc value, "discarding" and "halted" flags, sticky error, return queue.
   logic [3:0] m_pc = 4'h0;
   bit         m_fl = 1'b0, m_hl = 1'b0, m_err = 1'b0;
   logic [3:0] m_stk[$];

   function automatic bit cond_true(logic [1:0] c, logic z, logic n, logic cy);
      case (c)
         2'd0: return 1'b1;
         2'd1: return z;
         2'd2: return n;
         default: return cy;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_pc = 4'h0; m_fl = 0; m_hl = 0; m_err = 0; m_stk.delete();
      end else if (m_hl) begin
         if (resume && !halt_req) m_hl = 0;
      end else if (m_fl) begin
         m_fl = 0;
         if (halt_req) m_hl = 1;
      end else if (halt_req) begin
         m_hl = 1;
      end else if (stall) begin
         m_pc = m_pc;
      end else if (STK && call_en) begin
         if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 4'h1);
         else m_err = 1;
         m_pc = jmp_addr; m_fl = 1;
      end else if (STK && ret_en) begin
         if (m_stk.size() == 0) begin
            m_pc = m_pc + 4'h1; m_err = 1;
         end else begin
            m_pc = m_stk.pop_back(); m_fl = 1;
         end
      end else if (jmp_en && cond_true(jmp_cond, flag_z, flag_n, flag_c)) begin
         m_pc = jmp_addr; m_fl = 1;
      end else begin
         m_pc = m_pc + 4'h1;
      end
   end

   task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_pc", pc, m_pc);
         chk("model_flush", {3'b0, flush}, {3'b0, m_fl});
         chk("model_halted", {3'b0, halted}, {3'b0, m_hl});
         chk("model_stack_err", {3'b0, stack_err}, {3'b0, m_err});
      end
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic lit(logic [3:0] epc, bit efl, bit ehl, bit eerr);
      chk("lit_pc", pc, epc);
      chk("lit_flush", {3'b0, flush}, {3'b0, efl});
      chk("lit_halted", {3'b0, halted}, {3'b0, ehl});
      chk("lit_stack_err", {3'b0, stack_err}, {3'b0, eerr});
   endtask

   initial begin
      cyc(2);
      lit(4'h0, 0, 0, 0);
      cmp_en = 1'b1;
      rst_n  = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         cyc(1);
         lit(4'(k), 0, 0, 0);
      end
      cyc(3);
      // conditional on flag_z: not taken, then taken
      jmp_en = 1; jmp_cond = 2'b01; flag_z = 0; jmp_addr = 4'd9;
      cyc(1); lit(4'd4, 0, 0, 0);
      flag_z = 1;
      cyc(1); lit(4'd9, 1, 0, 0);
      jmp_en = 0; flag_z = 0;
      cyc(1); lit(4'd9, 0, 0, 0);
      cyc(1); lit(4'd10, 0, 0, 0);
      // flag_n condition; jump request during FLUSH is ignored
      jmp_en = 1; jmp_cond = 2'b10; flag_n = 0; jmp_addr = 4'd1;
      cyc(1); lit(4'd11, 0, 0, 0);
      flag_n = 1;
      cyc(1); lit(4'd1, 1, 0, 0);
      jmp_cond = 2'b00; jmp_addr = 4'd6;
      cyc(1); lit(4'd1, 0, 0, 0);
      jmp_en = 0; flag_n = 0;
      cyc(4); lit(4'd5, 0, 0, 0);
      // stall masks a pending flag_c jump
      stall = 1; jmp_en = 1; jmp_cond = 2'b11; flag_c = 1; jmp_addr = 4'd13;
      for (int k = 0; k < 3; k++) begin
         cyc(1); lit(4'd5, 0, 0, 0);
      end
      stall = 0;
      cyc(1); lit(4'd13, 1, 0, 0);
      jmp_en = 0; flag_c = 0;
      cyc(1); lit(4'd13, 0, 0, 0);
      cyc(10); lit(4'd7, 0, 0, 0);
      // halt beats stall; everything but resume ignored in HALT
      halt_req = 1; stall = 1;
      cyc(1); lit(4'd7, 0, 1, 0);
      halt_req = 0; stall = 0; jmp_en = 1; jmp_cond = 2'b00; jmp_addr = 4'd3;
      call_en = 1; ret_en = 1;
      for (int k = 0; k < 4; k++) begin
         cyc(1); lit(4'd7, 0, 1, 0);
      end
      jmp_en = 0; call_en = 0; ret_en = 0;
      halt_req = 1; resume = 1;
      cyc(1); lit(4'd7, 0, 1, 0);
      halt_req = 0;
      cyc(1); lit(4'd7, 0, 0, 0);
      resume = 0;
      cyc(1); lit(4'd8, 0, 0, 0);
      // halt requested during FLUSH, then reset out of HALT
      jmp_en = 1; jmp_addr = 4'd4;
      cyc(1); lit(4'd4, 1, 0, 0);
      jmp_en = 0; halt_req = 1;
      cyc(1); lit(4'd4, 0, 1, 0);
      halt_req = 0; rst_n = 0;
      cyc(1); lit(4'd0, 0, 0, 0);
      rst_n = 1; jmp_en = 1; jmp_addr = 4'd11;
      cyc(1); lit(4'd11, 1, 0, 0);
      jmp_en = 0; rst_n = 0;
      cyc(1); lit(4'd0, 0, 0, 0);
      rst_n = 1;
      cyc(1); lit(4'd1, 0, 0, 0);
`ifdef PC_CALL_STACK_EN
      cyc(1);
      call_en = 1; jmp_addr = 4'd12;
      cyc(1); lit(4'd12, 1, 0, 0);
      call_en = 0;
      cyc(1); lit(4'd12, 0, 0, 0);
      ret_en = 1;
      cyc(1); lit(4'd3, 1, 0, 0);
      ret_en = 0;
      cyc(1);
      for (int i = 0; i < 5; i++) begin
         call_en = 1; jmp_addr = 4'(i + 8);
         cyc(1); lit(4'(i + 8), 1, 0, (i == 4));
         call_en = 0;
         cyc(1);
      end
      for (int i = 0; i < 4; i++) begin
         ret_en = 1; cyc(1);
         ret_en = 0; cyc(1);
      end
      lit(4'd4, 0, 0, 1);
      rst_n = 0;
      cyc(1); lit(4'd0, 0, 0, 0);
      rst_n = 1; ret_en = 1;
      cyc(1); lit(4'd1, 0, 0, 1);
      ret_en = 0; stall = 1; call_en = 1;
      cyc(1); lit(4'd1, 0, 0, 1);
      stall = 0; call_en = 0;
`else
      call_en = 1; jmp_addr = 4'd12;
      cyc(1); lit(4'd2, 0, 0, 0);
      call_en = 0; ret_en = 1;
      cyc(1); lit(4'd3, 0, 0, 0);
      ret_en = 0;
`endif
      cyc(2);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
